// File: rtl/eth_reset_sequencer.sv
// eth_reset_sequencer: synchronizes board reset and PLL lock, then releases the
// PHY, MAC and UDP/IP stack resets in order with programmable hold/settle times.
// A software re-sequence request in RUN replays the release order and ends in a
// one-cycle acknowledge.
// Optional feature: define RST_LOCK_LOSS_EN to fall back to WAIT_LOCK when the
// PLL loses lock while in RUN (a pending software request is then dropped).
module eth_reset_sequencer #(
  parameter int PHY_RST_CYCLES   = 1000,
  parameter int PHY_WAIT_CYCLES  = 5000,
  parameter int STAGE_GAP_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pll_locked,
  input  logic i_sw_rst_req,
  output logic o_phy_rst_n,
  output logic o_mac_rst_n,
  output logic o_stack_rst_n,
  output logic o_rst_done,
  output logic o_sw_rst_ack
);

  localparam int MAX_AB     = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ? PHY_RST_CYCLES : PHY_WAIT_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > STAGE_GAP_CYCLES) ? MAX_AB : STAGE_GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  // Counter load values: a stage lasting N cycles starts at N-1 and exits at 0.
  localparam logic [CNT_W-1:0] PHY_RST_LOAD  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LOAD = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD      = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PHY_RST,
    PHY_WAIT,
    MAC_REL,
    RUN
  } state_t;

  logic [1:0]       rst_pipe;
  logic             rst_n;
  logic [1:0]       lock_pipe;
  logic             lock_sync;
  logic             run_lock_lost;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             pending;
  logic             pending_next;
  logic             phy_next;
  logic             mac_next;
  logic             stack_next;
  logic             done_next;
  logic             ack_next;

  // Reset synchronizer: asserts immediately with i_reset, releases after two clock edges.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // PLL lock synchronizer, held clear while the internal reset is active.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_pipe <= 2'b00;
    end else begin
      lock_pipe <= {lock_pipe[0], i_pll_locked};
    end
  end

  assign lock_sync = lock_pipe[1];

`ifdef RST_LOCK_LOSS_EN
  assign run_lock_lost = !lock_sync;
`else
  assign run_lock_lost = 1'b0;
`endif

  // Next-state, counter, pending flag and registered-output values.
  always_comb begin
    state_next   = state;
    count_next   = count;
    pending_next = pending;
    ack_next     = 1'b0;

    if (count != '0) begin
      count_next = count - CNT_ONE;
    end

    unique case (state)
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_next = PHY_RST;
          count_next = PHY_RST_LOAD;
        end
      end
      PHY_RST: begin
        if (!lock_sync) begin
          state_next = WAIT_LOCK;
          count_next = '0;
        end else if (count == '0) begin
          state_next = PHY_WAIT;
          count_next = PHY_WAIT_LOAD;
        end
      end
      PHY_WAIT: begin
        if (!lock_sync) begin
          state_next = WAIT_LOCK;
          count_next = '0;
        end else if (count == '0) begin
          state_next = MAC_REL;
          count_next = GAP_LOAD;
        end
      end
      MAC_REL: begin
        if (!lock_sync) begin
          state_next = WAIT_LOCK;
          count_next = '0;
        end else if (count == '0) begin
          state_next   = RUN;
          count_next   = '0;
          ack_next     = pending;
          pending_next = 1'b0;
        end
      end
      RUN: begin
        if (run_lock_lost) begin
          state_next   = WAIT_LOCK;
          count_next   = '0;
          pending_next = 1'b0;
        end else if (i_sw_rst_req) begin
          state_next   = PHY_RST;
          count_next   = PHY_RST_LOAD;
          pending_next = 1'b1;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        count_next = '0;
      end
    endcase

    phy_next   = (state_next == PHY_WAIT) || (state_next == MAC_REL) || (state_next == RUN);
    mac_next   = (state_next == MAC_REL) || (state_next == RUN);
    stack_next = (state_next == RUN);
    done_next  = (state_next == RUN);
  end

  // State, counter, pending flag and output registers.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      count         <= '0;
      pending       <= 1'b0;
      o_phy_rst_n   <= 1'b0;
      o_mac_rst_n   <= 1'b0;
      o_stack_rst_n <= 1'b0;
      o_rst_done    <= 1'b0;
      o_sw_rst_ack  <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      pending       <= pending_next;
      o_phy_rst_n   <= phy_next;
      o_mac_rst_n   <= mac_next;
      o_stack_rst_n <= stack_next;
      o_rst_done    <= done_next;
      o_sw_rst_ack  <= ack_next;
    end
  end

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// tb_eth_reset_sequencer: directed scenarios plus randomized lock/request/reset
// traffic, compared every cycle against a stage-based behavioural model.
module tb_eth_reset_sequencer;

  localparam int PHY_RST_CYCLES   = 4;
  localparam int PHY_WAIT_CYCLES  = 8;
  localparam int STAGE_GAP_CYCLES = 2;

`ifdef RST_LOCK_LOSS_EN
  localparam bit LOCK_LOSS_EN = 1'b1;
`else
  localparam bit LOCK_LOSS_EN = 1'b0;
`endif

  logic i_clk        = 1'b0;
  logic i_reset      = 1'b1;
  logic i_pll_locked = 1'b0;
  logic i_sw_rst_req = 1'b0;
  logic o_phy_rst_n;
  logic o_mac_rst_n;
  logic o_stack_rst_n;
  logic o_rst_done;
  logic o_sw_rst_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  // Model: stage 0 wait-lock, 1 PHY hold, 2 PHY settle, 3 MAC gap, 4 run.
  int m_stage   = 0;
  int m_elapsed = 0;
  int m_rst_age = 0;
  bit m_pending = 1'b0;
  bit m_ack     = 1'b0;
  bit m_lock_seen;
  bit m_lock_q[$];

  eth_reset_sequencer #(
    .PHY_RST_CYCLES  (PHY_RST_CYCLES),
    .PHY_WAIT_CYCLES (PHY_WAIT_CYCLES),
    .STAGE_GAP_CYCLES(STAGE_GAP_CYCLES)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pll_locked (i_pll_locked),
    .i_sw_rst_req (i_sw_rst_req),
    .o_phy_rst_n  (o_phy_rst_n),
    .o_mac_rst_n  (o_mac_rst_n),
    .o_stack_rst_n(o_stack_rst_n),
    .o_rst_done   (o_rst_done),
    .o_sw_rst_ack (o_sw_rst_ack)
  );

  // Free-running clock, period 10.
  always #5 i_clk = ~i_clk;

  // Rising-edge counter used to time events relative to a reference edge.
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  function automatic int stageLen(input int s);
    case (s)
      1:       return PHY_RST_CYCLES;
      2:       return PHY_WAIT_CYCLES;
      default: return STAGE_GAP_CYCLES;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, actual, expected, edge_cnt, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic lock, input logic sw);
    i_reset      = rst;
    i_pll_locked = lock;
    i_sw_rst_req = sw;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Pulses the software request for one cycle; returns the edge that samples it.
  task automatic pulseSw(output int sampled);
    i_sw_rst_req = 1'b1;
    sampled = edge_cnt + 1;
    @(negedge i_clk);
    i_sw_rst_req = 1'b0;
  endtask

  // Runs until o_rst_done is seen, recording first-high edges relative to ref_edge.
  task automatic waitDone(input int ref_edge, output int phy_rel, output int mac_rel,
                          output int done_rel, output int acks, output int ack_rel);
    phy_rel  = -1;
    mac_rel  = -1;
    done_rel = -1;
    acks     = 0;
    ack_rel  = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_phy_rst_n === 1'b1 && phy_rel < 0) phy_rel = edge_cnt - ref_edge;
      if (o_mac_rst_n === 1'b1 && mac_rel < 0) mac_rel = edge_cnt - ref_edge;
      if (o_sw_rst_ack === 1'b1) begin
        acks++;
        if (ack_rel < 0) ack_rel = edge_cnt - ref_edge;
      end
      if (o_rst_done === 1'b1) begin
        done_rel = edge_cnt - ref_edge;
        break;
      end
    end
    @(negedge i_clk);
    if (o_sw_rst_ack === 1'b1) acks++;
  endtask

  // Behavioural reference: reset/lock synchronizer delays and stage timing from the rules.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_rst_age = 0;
      m_stage   = 0;
      m_elapsed = 0;
      m_pending = 1'b0;
      m_ack     = 1'b0;
      m_lock_q.delete();
    end else if (m_rst_age < 2) begin
      m_rst_age++;
    end else begin
      m_lock_seen = (m_lock_q.size() >= 2) ? m_lock_q[m_lock_q.size() - 2] : 1'b0;
      m_lock_q.push_back(i_pll_locked);
      if (m_lock_q.size() > 4) void'(m_lock_q.pop_front());
      m_ack = 1'b0;
      if (m_stage == 0) begin
        if (m_lock_seen) begin
          m_stage   = 1;
          m_elapsed = 0;
        end
      end else if (m_stage == 4) begin
        if (LOCK_LOSS_EN && !m_lock_seen) begin
          m_stage   = 0;
          m_pending = 1'b0;
        end else if (i_sw_rst_req) begin
          m_stage   = 1;
          m_elapsed = 0;
          m_pending = 1'b1;
        end
      end else begin
        m_elapsed++;
        if (!m_lock_seen) begin
          m_stage = 0;
        end else if (m_elapsed == stageLen(m_stage)) begin
          m_stage++;
          m_elapsed = 0;
          if (m_stage == 4 && m_pending) begin
            m_ack     = 1'b1;
            m_pending = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    checkOutput("phy_rst_n",   o_phy_rst_n,   m_stage >= 2);
    checkOutput("mac_rst_n",   o_mac_rst_n,   m_stage >= 3);
    checkOutput("stack_rst_n", o_stack_rst_n, m_stage == 4);
    checkOutput("rst_done",    o_rst_done,    m_stage == 4);
    checkOutput("sw_rst_ack",  o_sw_rst_ack,  m_ack);
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int r_edge, s_edge, l_edge, d_edge;
    int phy_rel, mac_rel, done_rel, acks, ack_rel, fall_rel;

    #1 i_reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(3);

    // Power-up with lock already high.
    i_reset = 1'b1;
    r_edge = edge_cnt;
    waitDone(r_edge, phy_rel, mac_rel, done_rel, acks, ack_rel);
    checkOutput("startup_phy_edge",  phy_rel,  9);
    checkOutput("startup_mac_edge",  mac_rel,  17);
    checkOutput("startup_done_edge", done_rel, 19);
    checkOutput("startup_ack_count", acks,     0);

    // Software request in RUN.
    pulseSw(s_edge);
    checkOutput("sw_assert_phy",  o_phy_rst_n, 0);
    checkOutput("sw_assert_done", o_rst_done,  0);
    waitDone(s_edge, phy_rel, mac_rel, done_rel, acks, ack_rel);
    checkOutput("sw_phy_edge",  phy_rel,  4);
    checkOutput("sw_mac_edge",  mac_rel,  12);
    checkOutput("sw_done_edge", done_rel, 14);
    checkOutput("sw_ack_edge",  ack_rel,  14);
    checkOutput("sw_ack_count", acks,     1);

    // Software request during PHY_WAIT of a fresh start-up is ignored.
    i_reset = 1'b0;
    waitCycles(2);
    i_reset = 1'b1;
    r_edge = edge_cnt;
    waitCycles(11);
    pulseSw(s_edge);
    waitDone(r_edge, phy_rel, mac_rel, done_rel, acks, ack_rel);
    checkOutput("ignored_sw_done_edge", done_rel, 19);
    checkOutput("ignored_sw_ack_count", acks,     0);

    // Lock dropped during PHY_WAIT of a software re-sequence; pending flag survives.
    pulseSw(s_edge);
    waitCycles(4);
    i_pll_locked = 1'b0;
    waitCycles(3);
    checkOutput("lockdrop_phy_low", o_phy_rst_n, 0);
    waitCycles(7);
    i_pll_locked = 1'b1;
    l_edge = edge_cnt + 1;
    waitDone(l_edge, phy_rel, mac_rel, done_rel, acks, ack_rel);
    checkOutput("relock_phy_edge",  phy_rel,  6);
    checkOutput("relock_done_edge", done_rel, 16);
    checkOutput("relock_ack_count", acks,     1);

    // Asynchronous reset pulse in the middle of MAC_REL.
    pulseSw(s_edge);
    waitCycles(12);
    checkOutput("macrel_mac_high", o_mac_rst_n, 1);
    #2 i_reset = 1'b0;
    #1;
    checkOutput("async_phy_low", o_phy_rst_n,   0);
    checkOutput("async_mac_low", o_mac_rst_n,   0);
    checkOutput("async_stk_low", o_stack_rst_n, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    r_edge = edge_cnt;
    waitDone(r_edge, phy_rel, mac_rel, done_rel, acks, ack_rel);
    checkOutput("async_restart_done_edge", done_rel, 19);
    checkOutput("async_restart_ack_count", acks,     0);

    // Lock loss while in RUN.
    i_pll_locked = 1'b0;
    d_edge = edge_cnt;
`ifdef RST_LOCK_LOSS_EN
    fall_rel = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_rst_done === 1'b0) begin
        fall_rel = edge_cnt - d_edge;
        break;
      end
    end
    checkOutput("runlock_fall_within_3", (fall_rel >= 1) && (fall_rel <= 3), 1);
`else
    fall_rel = 0;
    waitCycles(10);
    checkOutput("runlock_done_held", o_rst_done, 1);
`endif
    i_pll_locked = 1'b1;
    waitCycles(25);

    // Randomized lock toggles, request pulses and asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      i_sw_rst_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) i_pll_locked = ~i_pll_locked;
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 4));
        i_reset = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
      end
    end
    @(negedge i_clk);
    i_sw_rst_req = 1'b0;
    waitCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
